// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN           default operand/result width
//   mdu_op_e       funct3 encodings of the M extension
//   mdu_state_e    control FSM states
//   is_signed_a/b  operand signedness per operation
package mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // MUL only keeps the low half, which is identical for signed and
    // unsigned operands, so it runs as unsigned.
    function automatic logic is_signed_a(input mdu_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation.
//   i_neg  negate when high
//   i_val  input value (W bits)
//   o_val  i_val or -i_val
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/iterative_mdu.sv
// Execute-stage RV32M unit: shift-add multiply and restoring divide, one
// bit per cycle, sharing one 2*XLEN accumulator.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_kill     op valid in EX / flush (kill wins)
//   i_funct3            M-extension operation
//   i_src_a, i_src_b    forwarded rs1 / rs2
//   o_busy              stall request (combinational, high in the start cycle)
//   o_done              one-cycle result strobe
//   o_result            result; holds the last value between strobes
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per cycle
// DONE  | sign-corrected result presented with o_done
module iterative_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e        r_state, w_state_nxt;
    mdu_op_e           r_op;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_opnd;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] r_acc;        // {hi,lo} product or {rem,quot}
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;

    mdu_op_e           w_op;
    logic              w_neg_a, w_neg_b;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_accept, w_special, w_done;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next, w_div_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_rem_sub;
    logic              w_rem_ge;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix, w_rem_fix, w_sel;

    assign w_op    = mdu_op_e'(i_funct3);
    assign w_neg_a = is_signed_a(w_op) & i_src_a[XLEN-1];
    assign w_neg_b = is_signed_b(w_op) & i_src_b[XLEN-1];

    mdu_negate #(.W(XLEN)) u_abs_a (.i_neg(w_neg_a), .i_val(i_src_a), .o_val(w_abs_a));
    mdu_negate #(.W(XLEN)) u_abs_b (.i_neg(w_neg_b), .i_val(i_src_b), .o_val(w_abs_b));

    // Divide by zero and signed overflow are resolved at accept time and
    // loaded straight into the accumulator as {rem,quot}.
    assign w_special = w_op[2] & ((i_src_b == '0) |
                       (is_signed_a(w_op) & (i_src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_src_b)));

    assign w_accept = (r_state == IDLE) & i_start & ~i_kill;
    assign o_busy   = w_accept | (r_state == CALC);
    assign w_done   = (r_state == DONE) & ~i_kill;

    // Multiply: add into upper half on multiplier LSB, carry shifts in on the right.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

    // Divide: shifted remainder needs one extra bit before the compare.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_opnd;
    assign w_div_next = w_rem_ge ? {w_rem_sub, r_acc[XLEN-2:0], 1'b1}
                                 : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    mdu_negate #(.W(2*XLEN)) u_fix_prod (.i_neg(r_neg_res), .i_val(r_acc), .o_val(w_prod_fix));
    mdu_negate #(.W(XLEN)) u_fix_quot (.i_neg(r_neg_res), .i_val(r_acc[XLEN-1:0]), .o_val(w_quot_fix));
    mdu_negate #(.W(XLEN)) u_fix_rem (.i_neg(r_neg_rem), .i_val(r_acc[2*XLEN-1:XLEN]), .o_val(w_rem_fix));

    always_comb begin
        w_sel = w_rem_fix;
        case (r_op)
            OP_MUL:                       w_sel = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_sel = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_sel = w_quot_fix;
            default:                      w_sel = w_rem_fix;
        endcase
    end

    assign o_done   = w_done;
    assign o_result = w_done ? w_sel : r_result;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
            CALC:    if (r_count == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_kill) w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_op      <= OP_MUL;
            r_count   <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= w_op;
                r_count <= CW'(XLEN-1);
                if (w_special) begin
                    r_neg_res <= 1'b0;
                    r_neg_rem <= 1'b0;
                    r_opnd    <= '0;
                    if (i_src_b == '0) r_acc <= {i_src_a, {XLEN{1'b1}}};
                    else               r_acc <= {{XLEN{1'b0}}, i_src_a};
                end else begin
                    r_neg_res <= w_neg_a ^ w_neg_b;
                    r_neg_rem <= w_neg_a;
                    r_opnd    <= w_op[2] ? w_abs_b : w_abs_a;
                    r_acc     <= {{XLEN{1'b0}}, (w_op[2] ? w_abs_a : w_abs_b)};
                end
            end else if (r_state == CALC) begin
                r_acc <= r_op[2] ? w_div_next : w_mul_next;
                if (r_count != '0) r_count <= r_count - CW'(1);
            end
            if (w_done) r_result <= w_sel;
        end
    end

endmodule
